display_scan_controller: RTL and testbench
==========================================

DISPLAY_SCAN_CONTROLLER -- requirements
Module: display_scan_controller

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk (rising edge) and rst.
REQ-002 Parameter SCAN_DIV, default 1000, SHALL set the clk cycles per digit slot (legal range >= 2).
REQ-003 Parameter LT_FRAMES, default 4, SHALL set the number of full frames a lamp test lasts (legal range >= 1).
REQ-004 Ports SHALL be (name  direction  width  meaning):
  clk  in  1  system clock
  rst  in  1  synchronous reset, active high
  digits_in  in  16  four BCD digits; [3:0] is digit 0 (least significant), [15:12] is digit 3
  load  in  1  single-cycle request to update the displayed value
  lt_req  in  1  single-cycle lamp-test request
  blank_en  in  1  level input; forces the display dark
  data  out  4  BCD code to the shared 7448 decoder
  LT  out  1  lamp test to the 7448, active high
  RBI  out  1  ripple-blanking input to the 7448, active high
  BI  out  1  blanking input to the 7448, active high
  digit_sel  out  4  one-hot common-electrode enable; bit i selects digit i
  frame_done  out  1  one-cycle pulse at each frame end
  lt_busy  out  1  high while a lamp test is running

Function
REQ-005 The block SHALL time-share one 7448 across 4 digits using a slot counter (0..SCAN_DIV-1) and a digit index (0..3).
REQ-006 The slot counter SHALL increment every clk; on SCAN_DIV-1 it SHALL wrap to 0 and the index SHALL advance by one, wrapping from 3 to 0.
REQ-007 All outputs SHALL be decoded only from registers, with no combinational path from any input to any output.
REQ-008 digit_sel SHALL equal 1<<index, and data SHALL equal the shadow register nibble for that index.
REQ-009 BI SHALL be 1 while the slot counter is 0 (anti-ghosting gap), SHALL be 1 whenever the blank_en register is 1, and SHALL be 0 otherwise.
REQ-010 RBI SHALL be 1 when index != 0 and every shadow digit j >= index is 0, and 0 otherwise; digit 0 SHALL never be suppressed.
REQ-011 The state machine SHALL have two states, SCAN and LAMP.
REQ-012 load SHALL capture digits_in into a pending register and set a pending flag.
REQ-013 The pending value SHALL be copied to the shadow register only on the index wrap from 3 to 0, which prevents tearing within a frame.
REQ-014 A second load before that wrap SHALL overwrite the pending value.
REQ-015 If load coincides with the wrap, the new value SHALL be the one applied.
REQ-016 frame_done SHALL be a one-cycle pulse, in the cycle after the index wraps from 3 to 0.
REQ-017 lt_req in SCAN SHALL transition the FSM to LAMP on the next edge and SHALL clear the slot counter and index to 0.
REQ-018 In LAMP, LT and lt_busy SHALL be 1 and all digits SHALL keep being scanned.
REQ-019 LAMP SHALL count completed frames and SHALL return to SCAN after LT_FRAMES frames; LT and lt_busy SHALL be 0 in the first SCAN cycle.
REQ-020 lt_req asserted while in LAMP SHALL be ignored.
REQ-021 blank_en SHALL be registered once; the BI override SHALL take effect one cycle after blank_en changes.
REQ-022 Scanning, loads and lamp-test frame counting SHALL continue while blank_en is active.

Reset
REQ-023 On rst the block SHALL set slot counter=0, index=0, shadow=0, pending=0, pending flag=0, FSM=SCAN and frame count=0.
REQ-024 The resulting reset output values SHALL be: data=0, digit_sel=4'b0001, BI=1, RBI=0, LT=0, frame_done=0, lt_busy=0.
REQ-025 rst asserted during LAMP SHALL abort the lamp test immediately.
REQ-026 rst SHALL discard any pending load.

Structure
REQ-027 A shared package display_pkg SHALL hold: the FSM state enum (SCAN, LAMP), NUM_DIGITS=4, BCD_W=4, and the default SCAN_DIV and LT_FRAMES constants.
REQ-028 The slot counter and index wrap logic SHALL be one sub-module, scan_tick_gen, with outputs slot_zero, index and wrap.
REQ-029 The RBI chain and the FSM SHALL remain in the top module.

Verification (SCAN_DIV=4, LT_FRAMES=2)
REQ-030 Reset released with no load -> digit_sel cycles 0001,0010,0100,1000 every 4 clks; RBI=1 on digits 1-3; RBI=0 and data=0 on digit 0; BI=1 on each slot's first clk.
REQ-031 load with 16'h0305 mid-frame -> old value shown until the wrap; the next frame shows data 5,0,3,0 on digits 0..3; RBI=1 only on digit 3.
REQ-032 Two loads (16'h1111 then 16'h2222) in the same frame -> next frame shows all 2s; 1s are never displayed.
REQ-033 lt_req in SCAN -> next clk: index=0, LT=1, lt_busy=1 for exactly 32 clks, then LT=0; an lt_req issued at clk 10 of the test has no effect.
REQ-034 blank_en high for 6 clks -> BI=1 from the clk after assertion until the clk after deassertion; digit_sel keeps rotating.
REQ-035 rst pulse during LAMP at frame 1 -> the next cycle shows the REQ-024 reset values, with LT=0 and lt_busy=0.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed 7448 display scanner.
package display_pkg;

  localparam int NUM_DIGITS        = 4;
  localparam int BCD_W             = 4;
  localparam int IDX_W             = $clog2(NUM_DIGITS);
  localparam int DEFAULT_SCAN_DIV  = 1000;
  localparam int DEFAULT_LT_FRAMES = 4;

  typedef enum logic {
    SCAN = 1'b0,
    LAMP = 1'b1
  } state_t;

endpackage

// File: rtl/scan_tick_gen.sv
// Slot counter and digit index: each digit is driven for SCAN_DIV clocks,
// and the index rolls 0..NUM_DIGITS-1. wrap flags the cycle before 3 -> 0.
module scan_tick_gen
  import display_pkg::*;
#(
  parameter int SCAN_DIV = DEFAULT_SCAN_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  output logic             slot_zero,
  output logic [IDX_W-1:0] index,
  output logic             wrap
);

  localparam int              CNT_W     = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] slot_cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      slot_cnt <= '0;
      index    <= '0;
    end else if (slot_cnt == SLOT_LAST) begin
      slot_cnt <= '0;
      index    <= (index == IDX_LAST) ? '0 : index + 1'b1;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  assign slot_zero = (slot_cnt == '0);
  assign wrap      = (slot_cnt == SLOT_LAST) && (index == IDX_LAST);

endmodule

// File: rtl/display_scan_controller.sv
// Time-shares one 7448 BCD decoder across four digits with tear-free updates,
// leading-zero blanking via RBI, and a frame-counted lamp test.
module display_scan_controller
  import display_pkg::*;
#(
  parameter int SCAN_DIV  = DEFAULT_SCAN_DIV,
  parameter int LT_FRAMES = DEFAULT_LT_FRAMES
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_DIGITS*BCD_W-1:0] digits_in,
  input  logic                        load,
  input  logic                        lt_req,
  input  logic                        blank_en,
  output logic [BCD_W-1:0]            data,
  output logic                        LT,
  output logic                        RBI,
  output logic                        BI,
  output logic [NUM_DIGITS-1:0]       digit_sel,
  output logic                        frame_done,
  output logic                        lt_busy
);

  localparam int              LF_W       = $clog2(LT_FRAMES + 1);
  localparam logic [LF_W-1:0] FRAME_LAST = LF_W'(LT_FRAMES - 1);

  state_t                      state;
  logic [LF_W-1:0]             lt_cnt;
  logic [NUM_DIGITS*BCD_W-1:0] shadow;
  logic [NUM_DIGITS*BCD_W-1:0] pending;
  logic                        pend_flag;
  logic                        blank_q;
  logic                        frame_done_q;
  logic                        slot_zero;
  logic                        wrap;
  logic [IDX_W-1:0]            index;
  logic                        clear;

  // A lamp test restarts the scan so it always covers whole frames.
  assign clear = (state == SCAN) && lt_req;

  scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .slot_zero (slot_zero),
    .index     (index),
    .wrap      (wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= SCAN;
      lt_cnt <= '0;
    end else begin
      case (state)
        SCAN: begin
          if (lt_req) begin
            state  <= LAMP;
            lt_cnt <= '0;
          end
        end
        LAMP: begin
          if (wrap) begin
            if (lt_cnt == FRAME_LAST) begin
              state  <= SCAN;
              lt_cnt <= '0;
            end else begin
              lt_cnt <= lt_cnt + 1'b1;
            end
          end
        end
        default: state <= SCAN;
      endcase
    end
  end

  // NOTE: shadow and pending are reset explicitly; the display must come up
  // showing zero and a stale pending value must never reach the shadow.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow       <= '0;
      pending      <= '0;
      pend_flag    <= 1'b0;
      blank_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      blank_q      <= blank_en;
      frame_done_q <= wrap;
      if (wrap) begin
        // A load landing on the wrap edge beats the older pending value.
        if (load)           shadow <= digits_in;
        else if (pend_flag) shadow <= pending;
        pend_flag <= 1'b0;
      end else if (load) begin
        pending   <= digits_in;
        pend_flag <= 1'b1;
      end
    end
  end

  assign data       = shadow[int'(index)*BCD_W +: BCD_W];
  assign digit_sel  = NUM_DIGITS'(1) << index;
  assign BI         = slot_zero || blank_q;
  assign LT         = (state == LAMP);
  assign lt_busy    = (state == LAMP);
  assign frame_done = frame_done_q;

  // Suppress a digit only when it and every more-significant digit are zero.
  // NOTE: RBI gets a default before the loop so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    RBI = (index != '0);
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (j >= int'(index) && shadow[j*BCD_W +: BCD_W] != '0) RBI = 1'b0;
    end
  end

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller with SCAN_DIV=4, LT_FRAMES=2.
module tb_display_scan_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] digits_in;
  logic        load;
  logic        lt_req;
  logic        blank_en;
  logic [3:0]  data;
  logic        LT;
  logic        RBI;
  logic        BI;
  logic [3:0]  digit_sel;
  logic        frame_done;
  logic        lt_busy;

  int n_checks = 0;
  int n_errors = 0;

  display_scan_controller #(.SCAN_DIV(4), .LT_FRAMES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .digits_in  (digits_in),
    .load       (load),
    .lt_req     (lt_req),
    .blank_en   (blank_en),
    .data       (data),
    .LT         (LT),
    .RBI        (RBI),
    .BI         (BI),
    .digit_sel  (digit_sel),
    .frame_done (frame_done),
    .lt_busy    (lt_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full frame from slot 0 / digit 0. shown and rbi_mask are the expected
  // displayed value and per-digit RBI; up to two loads are issued at cycles la/lb.
  task automatic check_frame(input string name, input logic [15:0] shown,
                             input logic [3:0] rbi_mask, input logic fd0,
                             input int la, input logic [15:0] va,
                             input int lb, input logic [15:0] vb);
    logic [3:0] exp_sel;
    for (int k = 0; k < 16; k++) begin
      int d;
      d = k / 4;
      exp_sel = 4'b0001 << d;
      check($sformatf("%s sel k%0d", name, k), 32'(digit_sel), 32'(exp_sel));
      check($sformatf("%s data k%0d", name, k), 32'(data), 32'(shown[d*4 +: 4]));
      check($sformatf("%s BI k%0d", name, k), 32'(BI), 32'((k % 4) == 0));
      check($sformatf("%s RBI k%0d", name, k), 32'(RBI), 32'(rbi_mask[d]));
      check($sformatf("%s fd k%0d", name, k), 32'(frame_done), (k == 0) ? 32'(fd0) : 32'd0);
      check($sformatf("%s LT k%0d", name, k), 32'(LT), 32'd0);
      if (k == la) begin load = 1'b1; digits_in = va; end
      if (k == lb) begin load = 1'b1; digits_in = vb; end
      tick();
      load = 1'b0;
    end
  endtask

  task automatic check_reset_values(input string name);
    check({name, " data"}, 32'(data), 32'd0);
    check({name, " sel"}, 32'(digit_sel), 32'h1);
    check({name, " BI"}, 32'(BI), 32'd1);
    check({name, " RBI"}, 32'(RBI), 32'd0);
    check({name, " LT"}, 32'(LT), 32'd0);
    check({name, " fd"}, 32'(frame_done), 32'd0);
    check({name, " busy"}, 32'(lt_busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; digits_in = '0; load = 1'b0; lt_req = 1'b0; blank_en = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    check_reset_values("reset");

    // Idle scan, then tear-free update, double load, load on the wrap edge.
    check_frame("idle",   16'h0000, 4'b1110, 1'b0, -1, '0, -1, '0);
    check_frame("ld0305", 16'h0000, 4'b1110, 1'b1,  6, 16'h0305, -1, '0);
    check_frame("show0305", 16'h0305, 4'b1000, 1'b1, 3, 16'h1111, 9, 16'h2222);
    check_frame("show2222", 16'h2222, 4'b0000, 1'b1, -1, '0, -1, '0);
    check_frame("wrapld", 16'h2222, 4'b0000, 1'b1, 4, 16'h4444, 15, 16'h0009);
    check_frame("show0009", 16'h0009, 4'b1110, 1'b1, -1, '0, -1, '0);

    // Lamp test requested mid-frame; a second request at m=10 is ignored.
    repeat (5) tick();
    lt_req = 1'b1;
    tick();
    lt_req = 1'b0;
    for (int m = 0; m < 32; m++) begin
      int d;
      d = (m / 4) % 4;
      check($sformatf("lamp LT m%0d", m), 32'(LT), 32'd1);
      check($sformatf("lamp busy m%0d", m), 32'(lt_busy), 32'd1);
      check($sformatf("lamp sel m%0d", m), 32'(digit_sel), 32'(4'b0001 << d));
      check($sformatf("lamp data m%0d", m), 32'(data), (d == 0) ? 32'd9 : 32'd0);
      check($sformatf("lamp BI m%0d", m), 32'(BI), 32'((m % 4) == 0));
      check($sformatf("lamp fd m%0d", m), 32'(frame_done), 32'(m == 16));
      if (m == 10) lt_req = 1'b1;
      tick();
      lt_req = 1'b0;
    end
    check("lamp end LT", 32'(LT), 32'd0);
    check("lamp end busy", 32'(lt_busy), 32'd0);
    check("lamp end sel", 32'(digit_sel), 32'h1);
    check("lamp end fd", 32'(frame_done), 32'd1);

    // blank_en high for six clocks starting at k=1.
    for (int k = 0; k < 12; k++) begin
      check($sformatf("blank BI k%0d", k), 32'(BI), 32'((k >= 2 && k <= 7) || (k % 4) == 0));
      check($sformatf("blank sel k%0d", k), 32'(digit_sel), 32'(4'b0001 << (k / 4)));
      if (k == 1) blank_en = 1'b1;
      if (k == 7) blank_en = 1'b0;
      tick();
    end

    // Reset during the second lamp frame, with a load pending.
    lt_req = 1'b1;
    tick();
    lt_req = 1'b0;
    repeat (17) tick();
    load = 1'b1; digits_in = 16'h7777;
    tick();
    load = 1'b0;
    check("lamp2 LT", 32'(LT), 32'd1);
    rst = 1'b1;
    tick();
    check_reset_values("lamp rst");
    rst = 1'b0;
    check_frame("post rst", 16'h0000, 4'b1110, 1'b0, -1, '0, -1, '0);
    check_frame("no pend", 16'h0000, 4'b1110, 1'b1, -1, '0, -1, '0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
